// File: rtl/reg_to_apb_if.sv
// Reg-bus and APB4 bundles used by the reg_to_apb bridge.
// Signal suffixes are given from the bridge's point of view.
interface reg_bus_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [AddrWidth-1:0] reg_addr_i;
  logic                 reg_write_i;
  logic [DataWidth-1:0] reg_wdata_i;
  logic [StrbWidth-1:0] reg_wstrb_i;
  logic                 reg_valid_i;
  logic [DataWidth-1:0] reg_rdata_o;
  logic                 reg_error_o;
  logic                 reg_ready_o;

  modport master (
    output reg_addr_i, reg_write_i,
    output reg_wdata_i, reg_wstrb_i,
    output reg_valid_i,
    input  reg_rdata_o, reg_error_o,
    input  reg_ready_o
  );

  modport slave (
    input  reg_addr_i, reg_write_i,
    input  reg_wdata_i, reg_wstrb_i,
    input  reg_valid_i,
    output reg_rdata_o, reg_error_o,
    output reg_ready_o
  );
endinterface

interface apb_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [AddrWidth-1:0] paddr_o;
  logic [2:0]           pprot_o;
  logic                 psel_o;
  logic                 penable_o;
  logic                 pwrite_o;
  logic [DataWidth-1:0] pwdata_o;
  logic [StrbWidth-1:0] pstrb_o;
  logic [DataWidth-1:0] prdata_i;
  logic                 pready_i;
  logic                 pslverr_i;

  modport master (
    output paddr_o, pprot_o, psel_o,
    output penable_o, pwrite_o,
    output pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, pprot_o, psel_o,
    input  penable_o, pwrite_o,
    input  pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/reg_to_apb.sv
// Reg-bus device port to APB4 requester bridge, one APB transfer per request.
// Optional ACCESS timeout abort enabled by defining REG_TO_APB_TIMEOUT_EN.
module reg_to_apb #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter logic [2:0]  ApbProt       = 3'b000,
  parameter int unsigned TimeoutCycles = 256
) (
  input logic      clk_i,
  input logic      rst_ni,
  reg_bus_if.slave reg_bus,
  apb_if.master    apb
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DataWidth-1:0] pwdata_q, pwdata_d;
  logic [StrbWidth-1:0] pstrb_q, pstrb_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic                 ready_q, ready_d;

`ifdef REG_TO_APB_TIMEOUT_EN
  localparam int unsigned CntWidth =
    $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                timeout;

  assign timeout =
    cnt_q == CntWidth'(TimeoutCycles - 1);
`endif

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = '0;
    error_d   = 1'b0;
    ready_d   = 1'b0;
`ifdef REG_TO_APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reg_bus.reg_valid_i) begin
          paddr_d   = reg_bus.reg_addr_i;
          pwrite_d  = reg_bus.reg_write_i;
          pwdata_d  = reg_bus.reg_wdata_i;
          pstrb_d   = reg_bus.reg_write_i ?
                      reg_bus.reg_wstrb_i : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef REG_TO_APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (apb.pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? '0 : apb.prdata_i;
          error_d   = apb.pslverr_i;
          state_d   = RESP;
`ifdef REG_TO_APB_TIMEOUT_EN
        end else if (timeout) begin
          // Abort: the completer never answered in time
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          error_d   = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d     = cnt_q + CntWidth'(1);
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
    end
  end

`ifdef REG_TO_APB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign apb.paddr_o     = paddr_q;
  assign apb.pprot_o     = ApbProt;
  assign apb.psel_o      = psel_q;
  assign apb.penable_o   = penable_q;
  assign apb.pwrite_o    = pwrite_q;
  assign apb.pwdata_o    = pwdata_q;
  assign apb.pstrb_o     = pstrb_q;
  assign reg_bus.reg_rdata_o = rdata_q;
  assign reg_bus.reg_error_o = error_q;
  assign reg_bus.reg_ready_o = ready_q;
endmodule

// File: tb/tb_reg_to_apb.sv
// Directed bench for reg_to_apb: phase timing, data, errors, reset, timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_to_apb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_bus_if rb ();
  apb_if     ab ();

  reg_to_apb #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .ApbProt      (3'b010),
    .TimeoutCycles(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .reg_bus(rb),
    .apb    (ab)
  );

  int errors = 0;
  int checks = 0;

  task automatic idle_inputs();
    rb.reg_addr_i  = '0;
    rb.reg_write_i = 1'b0;
    rb.reg_wdata_i = '0;
    rb.reg_wstrb_i = '0;
    rb.reg_valid_i = 1'b0;
    ab.prdata_i    = '0;
    ab.pready_i    = 1'b0;
    ab.pslverr_i   = 1'b0;
  endtask

  task automatic test_reset();
    logic [104:0] outs;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outs = {ab.paddr_o, ab.pwrite_o, ab.pwdata_o,
            ab.pstrb_o, ab.psel_o, ab.penable_o,
            rb.reg_rdata_o, rb.reg_error_o,
            rb.reg_ready_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rst_outs got %h exp 0", outs);
    end
    checks++;
    if (ab.pprot_o !== 3'b010) begin
      errors++;
      $display("FAIL rst_pprot got %b exp 010",
               ab.pprot_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ab.psel_o, rb.reg_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL rst_quiet got %b exp 00",
               {ab.psel_o, rb.reg_ready_o});
    end
  endtask

  task automatic test_zero_wait_write();
    logic [2:0] exp [0:4];
    logic [2:0] got;
    exp = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b000};
    @(negedge clk);
    rb.reg_addr_i  = 32'h1000_0004;
    rb.reg_write_i = 1'b1;
    rb.reg_wdata_i = 32'hDEAD_BEEF;
    rb.reg_wstrb_i = 4'hF;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      got = {ab.psel_o, ab.penable_o, rb.reg_ready_o};
      checks++;
      if (got !== exp[c]) begin
        errors++;
        $display("FAIL zw_phase c=%0d got %b exp %b",
                 c, got, exp[c]);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if ({ab.paddr_o, ab.pwrite_o, ab.pwdata_o,
             ab.pstrb_o} !==
            {32'h1000_0004, 1'b1, 32'hDEAD_BEEF,
             4'hF}) begin
          errors++;
          $display("FAIL zw_bus c=%0d got %h %b %h %h",
                   c, ab.paddr_o, ab.pwrite_o,
                   ab.pwdata_o, ab.pstrb_o);
        end
      end
      if (c == 3) begin
        checks++;
        if (rb.reg_error_o !== 1'b0) begin
          errors++;
          $display("FAIL zw_err got %b exp 0",
                   rb.reg_error_o);
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_read_wait();
    logic [2:0] exp [0:7];
    logic [2:0] got;
    exp = '{3'b000, 3'b100, 3'b110, 3'b110,
            3'b110, 3'b110, 3'b001, 3'b000};
    @(negedge clk);
    rb.reg_addr_i  = 32'h0000_0020;
    rb.reg_write_i = 1'b0;
    rb.reg_wstrb_i = 4'hA;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b0;
    ab.prdata_i    = 32'hFFFF_0000;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      got = {ab.psel_o, ab.penable_o, rb.reg_ready_o};
      checks++;
      if (got !== exp[c]) begin
        errors++;
        $display("FAIL rd_phase c=%0d got %b exp %b",
                 c, got, exp[c]);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if ({ab.pstrb_o, ab.pwrite_o,
             ab.paddr_o} !== {4'h0, 1'b0,
                              32'h20}) begin
          errors++;
          $display("FAIL rd_bus c=%0d got %h %b %h",
                   c, ab.pstrb_o, ab.pwrite_o,
                   ab.paddr_o);
        end
      end
      if (c == 5) begin
        ab.pready_i = 1'b1;
        ab.prdata_i = 32'h1234_5678;
      end
      if (c == 6) begin
        checks++;
        if (rb.reg_rdata_o !== 32'h1234_5678) begin
          errors++;
          $display("FAIL rd_data got %h exp 12345678",
                   rb.reg_rdata_o);
        end
        idle_inputs();
      end
      if (c == 7) begin
        checks++;
        if (rb.reg_rdata_o !== '0) begin
          errors++;
          $display("FAIL rd_data_clr got %h exp 0",
                   rb.reg_rdata_o);
        end
      end
    end
  endtask

  task automatic test_slave_error();
    logic [33:0] got;
    @(negedge clk);
    rb.reg_addr_i  = 32'h30;
    rb.reg_write_i = 1'b1;
    rb.reg_wdata_i = 32'h1;
    rb.reg_wstrb_i = 4'h3;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b1;
    ab.pslverr_i   = 1'b1;
    ab.prdata_i    = 32'hBAD0_BAD0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      got = {rb.reg_ready_o, rb.reg_error_o,
             rb.reg_rdata_o};
      if (c == 3) begin
        checks++;
        if (got !== {1'b1, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL err_resp got %h exp 3_00000000",
                   got);
        end
        idle_inputs();
      end
      if (c == 4) begin
        checks++;
        if (got[33:32] !== 2'b00) begin
          errors++;
          $display("FAIL err_pulse got %b exp 00",
                   got[33:32]);
        end
      end
    end
    rb.reg_addr_i  = 32'h34;
    rb.reg_write_i = 1'b0;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b1;
    ab.pslverr_i   = 1'b0;
    ab.prdata_i    = 32'hCAFE_0001;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      got = {rb.reg_ready_o, rb.reg_error_o,
             rb.reg_rdata_o};
      if (c == 3) begin
        checks++;
        if (got !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
          errors++;
          $display("FAIL err_next got %h exp 2_cafe0001",
                   got);
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    logic exp_sel;
    @(negedge clk);
    rb.reg_addr_i  = 32'h40;
    rb.reg_write_i = 1'b0;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b1;
    ab.prdata_i    = 32'h55AA_55AA;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      exp_rdy = (c % 4 == 3);
      exp_sel = (c % 4 == 1) || (c % 4 == 2);
      if (c == 12) exp_sel = 1'b0;
      checks++;
      if ({ab.psel_o, rb.reg_ready_o} !==
          {exp_sel, exp_rdy}) begin
        errors++;
        $display("FAIL b2b_phase c=%0d got %b exp %b",
                 c, {ab.psel_o, rb.reg_ready_o},
                 {exp_sel, exp_rdy});
      end
      if (c % 4 == 1 && c < 12) begin
        checks++;
        if (ab.paddr_o !== 32'h40 + 32'(4 * (c / 4)))
        begin
          errors++;
          $display("FAIL b2b_addr c=%0d got %h",
                   c, ab.paddr_o);
        end
      end
      if (exp_rdy) begin
        checks++;
        if (rb.reg_rdata_o !== 32'h55AA_55AA) begin
          errors++;
          $display("FAIL b2b_data c=%0d got %h",
                   c, rb.reg_rdata_o);
        end
        rb.reg_addr_i = rb.reg_addr_i + 32'h4;
      end
      if (c == 11) idle_inputs();
    end
  endtask

  task automatic test_reset_mid_access();
    logic [104:0] outs;
    int bad;
    @(negedge clk);
    rb.reg_addr_i  = 32'h3C;
    rb.reg_write_i = 1'b1;
    rb.reg_wdata_i = 32'hA5A5_0F0F;
    rb.reg_wstrb_i = 4'hC;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ab.psel_o, ab.penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL rma_access got %b exp 11",
               {ab.psel_o, ab.penable_o});
    end
    rst_n = 1'b0;
    #1;
    outs = {ab.paddr_o, ab.pwrite_o, ab.pwdata_o,
            ab.pstrb_o, ab.psel_o, ab.penable_o,
            rb.reg_rdata_o, rb.reg_error_o,
            rb.reg_ready_o};
    checks++;
    if (outs !== '0 || ab.pprot_o !== 3'b010) begin
      errors++;
      $display("FAIL rma_outs got %h prot %b", outs,
               ab.pprot_o);
    end
    idle_inputs();
    ab.pready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rb.reg_ready_o || ab.psel_o) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rma_no_resp got %0d exp 0", bad);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
`ifdef REG_TO_APB_TIMEOUT_EN
    logic [2:0] exp [0:7];
    logic [2:0] got;
    exp = '{3'b000, 3'b100, 3'b110, 3'b110,
            3'b110, 3'b110, 3'b001, 3'b000};
    @(negedge clk);
    rb.reg_addr_i  = 32'h50;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b0;
    ab.prdata_i    = 32'h7777_7777;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      got = {ab.psel_o, ab.penable_o, rb.reg_ready_o};
      checks++;
      if (got !== exp[c]) begin
        errors++;
        $display("FAIL to_phase c=%0d got %b exp %b",
                 c, got, exp[c]);
      end
      if (c == 6) begin
        checks++;
        if ({rb.reg_error_o, rb.reg_rdata_o} !==
            {1'b1, 32'h0}) begin
          errors++;
          $display("FAIL to_resp got %b %h exp 1 0",
                   rb.reg_error_o, rb.reg_rdata_o);
        end
        idle_inputs();
      end
    end
`else
    int held;
    @(negedge clk);
    rb.reg_addr_i  = 32'h50;
    rb.reg_valid_i = 1'b1;
    ab.pready_i    = 1'b0;
    repeat (2) @(negedge clk);
    held = 0;
    for (int c = 0; c < 1000; c++) begin
      if (ab.psel_o && ab.penable_o &&
          !rb.reg_ready_o) held++;
      @(negedge clk);
    end
    checks++;
    if (held !== 1000) begin
      errors++;
      $display("FAIL to_hold got %0d exp 1000", held);
    end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_slave_error();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_to_apb.md
# reg_to_apb

Bridge from the register-interface (reg bus) device side to an APB4 requester port. It lets a reg-bus initiator reach APB peripherals, so it is the counterpart of the APB-to-reg converter. Each accepted reg-bus request becomes exactly one APB transfer with a proper SETUP and ACCESS phase. The APB read data and error are returned to the reg bus through a registered response cycle.

## Interface
- `AddrWidth`, 32, width of the reg-bus and APB address.
- `DataWidth`, 32, width of the data path; must be a multiple of 8; `StrbWidth = DataWidth/8`.
- `ApbProt`, 3'b000, constant driven on `pprot_o`.
- `TimeoutCycles`, 256, maximum number of ACCESS cycles before abort; only used with `REG_TO_APB_TIMEOUT_EN`; must be ≥1.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `reg_addr_i`  in  AddrWidth  request address.
- `reg_write_i`  in  1  1 = write, 0 = read.
- `reg_wdata_i`  in  DataWidth  write data.
- `reg_wstrb_i`  in  StrbWidth  write byte strobes.
- `reg_valid_i`  in  1  request valid; held by the initiator until `reg_ready_o`.
- `reg_rdata_o`  out  DataWidth  read data; valid while `reg_ready_o` is high.
- `reg_error_o`  out  1  response error; valid while `reg_ready_o` is high.
- `reg_ready_o`  out  1  request completes in this cycle.
- `paddr_o`, `pprot_o`, `psel_o`, `penable_o`, `pwrite_o`, `pwdata_o`, `pstrb_o`  out  APB4 requester outputs, all registered.
- `prdata_i`, `pready_i`, `pslverr_i`  in  APB4 completer responses.

## Operation
- Four-state FSM: IDLE, SETUP, ACCESS, RESP.
- **IDLE**, with `reg_valid_i` high:
  - latch the request into the APB output registers;
  - `pstrb_o` gets `reg_wstrb_i` on writes and `'0` on reads;
  - go to SETUP.
- **SETUP**: `psel_o`=1, `penable_o`=0. Always go to ACCESS.
- **ACCESS**: `psel_o`=1, `penable_o`=1.
  - While `pready_i` is low, stay in ACCESS.
  - On `pready_i`=1: capture `prdata_i` (reads only; writes return `'0`) and `pslverr_i` into the response registers. Then go to RESP.
- **RESP**:
  - `reg_ready_o`=1 for exactly one cycle, with the registered `reg_rdata_o` and `reg_error_o`;
  - `psel_o` and `penable_o` are 0;
  - go to IDLE.
- Address, write, wdata and strobe outputs stay stable from SETUP through the end of ACCESS.
- Back-to-back requests: if `reg_valid_i` is high in the IDLE cycle after RESP, it is a new request. There is no implicit retry.
- If `reg_valid_i` drops mid-transfer, that is an initiator protocol violation. The APB transfer and the RESP cycle still complete normally.
- `reg_ready_o`, `reg_error_o` and `reg_rdata_o` are 0 outside RESP.
- Reset values, asserted asynchronously at any time including mid-transfer:
  - FSM in IDLE;
  - every output 0, except `pprot_o`, which is `ApbProt`;
  - no response is issued for a transfer that reset interrupted.

## Timing
- Request with valid in cycle 0 and zero APB wait states:
  - SETUP in cycle 1;
  - ACCESS in cycle 2, where `pready_i`=1;
  - `reg_ready_o` in cycle 3.
- Minimum latency is 3 cycles. Each APB wait state adds 1 cycle.
- Throughput: one transfer per 4 cycles at best, because IDLE is re-entered between transfers.
- There is no combinational path from any input to any output.

## Configuration
- `REG_TO_APB_TIMEOUT_EN` defined:
  - a cycle counter of `$clog2(TimeoutCycles+1)` bits clears on entry to ACCESS and increments each ACCESS cycle while `pready_i` is low;
  - if `pready_i` is still low on the cycle the counter reaches `TimeoutCycles-1`, the transfer is aborted: next state is RESP with `reg_error_o`=1 and `reg_rdata_o`=0, and `psel_o` and `penable_o` drop to 0;
  - a `pready_i`=1 arriving on that same cycle takes priority and gives a normal completion.
- `REG_TO_APB_TIMEOUT_EN` undefined: no counter is built, and ACCESS waits for `pready_i` indefinitely.

## Test plan
- **Zero-wait write**: write, addr 0x1000_0004, wdata 0xDEAD_BEEF, wstrb 0xF, `pready_i` tied 1.
  - `psel_o`=1 in cycles 1–2, `penable_o`=1 in cycle 2.
  - `reg_ready_o`=1 in cycle 3 with `reg_error_o`=0.
- **Read with 3 wait states**: read, addr 0x20; `pready_i` rises in the 4th ACCESS cycle with prdata 0x1234_5678.
  - `pstrb_o`=0 throughout.
  - `reg_rdata_o`=0x1234_5678 with `reg_ready_o` 6 cycles after the request.
- **Slave error**: `pslverr_i`=1 together with `pready_i`.
  - `reg_error_o`=1 for exactly one cycle.
  - The next request completes with error 0.
- **Back-to-back**: `reg_valid_i` held high for 3 consecutive requests, zero wait.
  - `reg_ready_o` pulses at cycles 3, 7 and 11.
  - There is no APB phase overlap.
- **Reset mid-ACCESS**: assert `rst_ni`=0 in the 2nd wait cycle.
  - All outputs go 0 immediately, with `pprot_o`=`ApbProt`.
  - No `reg_ready_o` pulse appears after reset releases.
- **Timeout** (macro on, `TimeoutCycles`=4): `pready_i` held 0.
  - ACCESS lasts 4 cycles, then `reg_ready_o`=1 with `reg_error_o`=1 and rdata 0.
  - With the macro off, the same stimulus leaves ACCESS held for 1000 cycles.
